// File: rtl/dac_mcp4822_spi.sv
// SPI write-only master for the MCP4822 dual 12-bit DAC: two 16-bit frames, then an LDAC pulse.
// Optional build macro DAC_SHDN_EN adds per-channel shutdown inputs i_shdn_a / i_shdn_b.
module dac_mcp4822_spi #(
    parameter int   CLK_DIV         = 4,
    parameter int   CS_SETUP_CYCLES = 2,
    parameter int   CS_HIGH_CYCLES  = 8,
    parameter int   LDAC_CYCLES     = 4,
    parameter logic GA_A            = 1'b1,
    parameter logic GA_B            = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] i_data_a,
    input  logic [11:0] i_data_b,
`ifdef DAC_SHDN_EN
    input  logic        i_shdn_a,
    input  logic        i_shdn_b,
`endif
    input  logic        i_valid,
    output logic        o_ready,
    output logic        MOSI,
    output logic        SCK,
    output logic        CS,
    output logic        LDAC
);

    typedef logic [15:0] cnt_t;

    typedef enum logic [3:0] {
        IDLE,
        SETUP_A,
        SHIFT_A,
        HOLD_A,
        GAP_A,
        SETUP_B,
        SHIFT_B,
        HOLD_B,
        GAP_B,
        LATCH
    } state_t;

    localparam cnt_t DIV_LOAD   = cnt_t'(CLK_DIV - 1);
    localparam cnt_t SETUP_LOAD = cnt_t'(CS_SETUP_CYCLES - 1);
    localparam cnt_t HIGH_LOAD  = cnt_t'(CS_HIGH_CYCLES - 1);
    localparam cnt_t LDAC_LOAD  = cnt_t'(LDAC_CYCLES - 1);

    logic shdn_a;
    logic shdn_b;

`ifdef DAC_SHDN_EN
    assign shdn_a = ~i_shdn_a;
    assign shdn_b = ~i_shdn_b;
`else
    assign shdn_a = 1'b1;
    assign shdn_b = 1'b1;
`endif

    state_t      state_q,  state_d;
    cnt_t        cnt_q,    cnt_d;
    logic [3:0]  bit_q,    bit_d;
    logic        phase_q,  phase_d;
    logic [15:0] shreg_q,  shreg_d;
    logic [15:0] word_b_q, word_b_d;

    logic cs_q,    cs_d;
    logic sck_q,   sck_d;
    logic mosi_q,  mosi_d;
    logic ldac_q,  ldac_d;
    logic ready_q, ready_d;
    logic cs_low_d;

    // Every state times out on a saturating down-counter reloaded at state entry.
    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q != '0) ? cnt_q - 16'd1 : '0;
        bit_d    = bit_q;
        phase_d  = phase_q;
        shreg_d  = shreg_q;
        word_b_d = word_b_q;

        case (state_q)
            IDLE: begin
                if (i_valid && ready_q) begin
                    state_d  = SETUP_A;
                    cnt_d    = SETUP_LOAD;
                    shreg_d  = {1'b0, 1'b0, GA_A, shdn_a, i_data_a};
                    word_b_d = {1'b1, 1'b0, GA_B, shdn_b, i_data_b};
                end
            end
            SETUP_A, SETUP_B: begin
                if (cnt_q == '0) begin
                    state_d = (state_q == SETUP_A) ? SHIFT_A : SHIFT_B;
                    cnt_d   = DIV_LOAD;
                    phase_d = 1'b0;
                    bit_d   = 4'd15;
                end
            end
            SHIFT_A, SHIFT_B: begin
                if (cnt_q == '0) begin
                    cnt_d = DIV_LOAD;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (bit_q == 4'd0) begin
                        state_d = (state_q == SHIFT_A) ? HOLD_A : HOLD_B;
                        cnt_d   = SETUP_LOAD;
                        phase_d = 1'b0;
                    end else begin
                        // Next bit appears only as the new low phase begins.
                        phase_d = 1'b0;
                        bit_d   = bit_q - 4'd1;
                        shreg_d = {shreg_q[14:0], 1'b0};
                    end
                end
            end
            HOLD_A: begin
                if (cnt_q == '0) begin
                    state_d = GAP_A;
                    cnt_d   = HIGH_LOAD;
                end
            end
            HOLD_B: begin
                if (cnt_q == '0) begin
                    state_d = GAP_B;
                    cnt_d   = HIGH_LOAD;
                end
            end
            GAP_A: begin
                if (cnt_q == '0) begin
                    state_d = SETUP_B;
                    cnt_d   = SETUP_LOAD;
                    shreg_d = word_b_q;
                end
            end
            GAP_B: begin
                if (cnt_q == '0) begin
                    state_d = LATCH;
                    cnt_d   = LDAC_LOAD;
                end
            end
            LATCH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from next-state values so the registered pins line up with state_q.
    always_comb begin
        cs_low_d = (state_d == SETUP_A) || (state_d == SHIFT_A) || (state_d == HOLD_A) ||
                   (state_d == SETUP_B) || (state_d == SHIFT_B) || (state_d == HOLD_B);
        cs_d     = ~cs_low_d;
        mosi_d   = cs_low_d & shreg_d[15];
        sck_d    = ((state_d == SHIFT_A) || (state_d == SHIFT_B)) & phase_d;
        ldac_d   = (state_d != LATCH);
        ready_d  = (state_d == IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments and every register, data included,
    // is forced by the asynchronous reset so an aborted frame leaves no stale word behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            phase_q  <= 1'b0;
            shreg_q  <= '0;
            word_b_q <= '0;
            cs_q     <= 1'b1;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            ldac_q   <= 1'b1;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            phase_q  <= phase_d;
            shreg_q  <= shreg_d;
            word_b_q <= word_b_d;
            cs_q     <= cs_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            ldac_q   <= ldac_d;
            ready_q  <= ready_d;
        end
    end

    assign o_ready = ready_q;
    assign MOSI    = mosi_q;
    assign SCK     = sck_q;
    assign CS      = cs_q;
    assign LDAC    = ldac_q;

endmodule

// File: tb/tb_dac_mcp4822_spi.sv
// Self-checking bench for dac_mcp4822_spi: table-driven frame/timing vectors plus
// hand-written sequences for busy-ignore, back-to-back, and mid-frame reset.
module tb_dac_mcp4822_spi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] i_data_a = '0;
    logic [11:0] i_data_b = '0;
    logic        i_shdn_a = 1'b0;
    logic        i_shdn_b = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready, MOSI, SCK, CS, LDAC;

    dac_mcp4822_spi dut (
        .clk      (clk),
        .rst      (rst),
        .i_data_a (i_data_a),
        .i_data_b (i_data_b),
`ifdef DAC_SHDN_EN
        .i_shdn_a (i_shdn_a),
        .i_shdn_b (i_shdn_b),
`endif
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .MOSI     (MOSI),
        .SCK      (SCK),
        .CS       (CS),
        .LDAC     (LDAC)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: times are the index of the clock edge at which the value is sampled.
    logic [15:0] frames[$];
    int          frame_rises[$];
    int          cs_fall_q[$];
    int          cs_rise_q[$];
    int          first_rise_q[$];
    int          ldac_start_q[$];
    int          ldac_len_q[$];
    int          accept_q[$];
    int          ready_rise_q[$];
    int          overlap = 0;

    initial begin : monitor
        logic [15:0] sh;
        int   rises, fall_t, first_t, ldac_t, l;
        logic cs_p, sck_p, ldac_p, rdy_p;
        sh = '0; rises = 0; fall_t = 0; first_t = 0; ldac_t = 0;
        cs_p = 1'b1; sck_p = 1'b0; ldac_p = 1'b1; rdy_p = 1'b1;
        forever begin
            @(negedge clk);
            l = cyc + 1;
            if (rst) begin
                sh = '0; rises = 0;
                cs_p = 1'b1; sck_p = 1'b0; ldac_p = 1'b1; rdy_p = 1'b1;
            end else begin
                if (i_valid && o_ready) accept_q.push_back(l);
                if (!CS && cs_p) begin
                    fall_t = l; rises = 0; sh = '0; first_t = 0;
                end
                if (!CS && SCK && !sck_p) begin
                    sh = {sh[14:0], MOSI};
                    if (rises == 0) first_t = l;
                    rises++;
                end
                if (CS && !cs_p) begin
                    frames.push_back(sh);
                    frame_rises.push_back(rises);
                    cs_fall_q.push_back(fall_t);
                    cs_rise_q.push_back(l);
                    first_rise_q.push_back(first_t);
                end
                if (!LDAC && ldac_p) ldac_t = l;
                if (LDAC && !ldac_p) begin
                    ldac_start_q.push_back(ldac_t);
                    ldac_len_q.push_back(l - ldac_t);
                end
                if (!LDAC && !CS) overlap++;
                if (o_ready && !rdy_p) ready_rise_q.push_back(l);
                cs_p = CS; sck_p = SCK; ldac_p = LDAC; rdy_p = o_ready;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        frames.delete(); frame_rises.delete(); cs_fall_q.delete(); cs_rise_q.delete();
        first_rise_q.delete(); ldac_start_q.delete(); ldac_len_q.delete();
        accept_q.delete(); ready_rise_q.delete();
    endtask

    task automatic wait_ready(input int max_cycles);
        int n;
        n = 0;
        while (!o_ready && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_ready_timeout", int'(o_ready), 1);
    endtask

    task automatic do_txn(input logic [11:0] a, input logic [11:0] b,
                          input logic sa, input logic sb);
        wait_ready(600);
        i_data_a = a; i_data_b = b; i_shdn_a = sa; i_shdn_b = sb;
        i_valid  = 1'b1;
        @(posedge clk); #1;
        i_valid  = 1'b0;
        i_data_a = ~a; i_data_b = ~b; i_shdn_a = ~sa; i_shdn_b = ~sb;
    endtask

    task automatic wait_done(input int max_cycles);
        int n;
        n = 0;
        while (ready_rise_q.size() == 0 && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_timeout", int'(ready_rise_q.size() > 0), 1);
    endtask

    task automatic check_txn(input string tag, input logic [15:0] wa, input logic [15:0] wb);
        int t0;
        t0 = (accept_q.size() > 0) ? accept_q[0] : 0;
        check({tag, "_accepts"}, accept_q.size(), 1);
        check({tag, "_frames"}, frames.size(), 2);
        if (frames.size() >= 2) begin
            check({tag, "_word_a"}, int'(frames[0]), int'(wa));
            check({tag, "_word_b"}, int'(frames[1]), int'(wb));
            check({tag, "_rises_a"}, frame_rises[0], 16);
            check({tag, "_rises_b"}, frame_rises[1], 16);
            check({tag, "_csfall_a"}, cs_fall_q[0] - t0, 1);
            check({tag, "_csrise_a"}, cs_rise_q[0] - t0, 133);
            check({tag, "_csfall_b"}, cs_fall_q[1] - t0, 141);
            check({tag, "_csrise_b"}, cs_rise_q[1] - t0, 273);
            check({tag, "_setup_a"}, int'(first_rise_q[0] - cs_fall_q[0] >= 2), 1);
        end
        check({tag, "_ldac_pulses"}, ldac_start_q.size(), 1);
        if (ldac_start_q.size() >= 1) begin
            check({tag, "_ldac_start"}, ldac_start_q[0] - t0, 281);
            check({tag, "_ldac_len"}, ldac_len_q[0], 4);
        end
        if (ready_rise_q.size() >= 1)
            check({tag, "_ready_back"}, ready_rise_q[0] - t0, 285);
    endtask

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic        sa;
        logic        sb;
        logic [15:0] wa;
        logic [15:0] wb;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int t0;
        logic found;

        vecs[0] = '{12'hABC, 12'h123, 1'b0, 1'b0, 16'h3ABC, 16'hB123};
        vecs[1] = '{12'h000, 12'h000, 1'b0, 1'b0, 16'h3000, 16'hB000};
        vecs[2] = '{12'hFFF, 12'hFFF, 1'b0, 1'b0, 16'h3FFF, 16'hBFFF};
        vecs[3] = '{12'h555, 12'hAAA, 1'b0, 1'b0, 16'h3555, 16'hBAAA};
`ifdef DAC_SHDN_EN
        vecs[4] = '{12'h800, 12'h800, 1'b1, 1'b0, 16'h2800, 16'hB800};
        vecs[5] = '{12'h123, 12'h456, 1'b1, 1'b1, 16'h2123, 16'hA456};
`else
        vecs[4] = '{12'h800, 12'h800, 1'b1, 1'b0, 16'h3800, 16'hB800};
        vecs[5] = '{12'h123, 12'h456, 1'b1, 1'b1, 16'h3123, 16'hB456};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cs", int'(CS), 1);
        check("rst_sck", int'(SCK), 0);
        check("rst_mosi", int'(MOSI), 0);
        check("rst_ldac", int'(LDAC), 1);
        check("rst_ready", int'(o_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            clear_log();
            do_txn(vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb);
            wait_done(400);
            check_txn($sformatf("vec%0d", i), vecs[i].wa, vecs[i].wb);
        end

        // Request during a busy transaction is dropped
        clear_log();
        do_txn(12'h000, 12'h000, 1'b0, 1'b0);
        t0 = (accept_q.size() > 0) ? accept_q[0] : 0;
        while (cyc < t0 + 49) begin
            @(posedge clk); #1;
        end
        i_data_a = 12'hFFF; i_data_b = 12'hFFF; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        wait_done(400);
        repeat (300) @(posedge clk);
        #1;
        check_txn("busy", 16'h3000, 16'hB000);

        // i_valid held high: back-to-back transactions
        clear_log();
        wait_ready(600);
        i_data_a = 12'h555; i_data_b = 12'hAAA; i_shdn_a = 1'b0; i_shdn_b = 1'b0;
        i_valid = 1'b1;
        for (int n = 0; n < 1200 && accept_q.size() < 3; n++) begin
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("b2b_accepts", accept_q.size(), 3);
        if (accept_q.size() >= 3) begin
            check("b2b_gap1", accept_q[1] - accept_q[0], 285);
            check("b2b_gap2", accept_q[2] - accept_q[1], 285);
        end
        check("b2b_frames", frames.size(), 6);
        for (int k = 0; k < 6 && k < frames.size(); k++) begin
            check($sformatf("b2b_word%0d", k), int'(frames[k]), (k % 2 == 0) ? 'h3555 : 'hBAAA);
            check($sformatf("b2b_rises%0d", k), frame_rises[k], 16);
        end
        check("b2b_ldac_pulses", ldac_len_q.size(), 3);

        // Reset mid SHIFT_A while SCK and MOSI are both high
        clear_log();
        do_txn(12'hABC, 12'h123, 1'b0, 1'b0);
        t0 = (accept_q.size() > 0) ? accept_q[0] : 0;
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (SCK && MOSI && !CS && (cyc + 1 >= t0 + 50)) found = 1'b1;
        end
        check("abort_window", int'(found), 1);
        #1 rst = 1'b1;
        #1;
        check("abort_cs", int'(CS), 1);
        check("abort_sck", int'(SCK), 0);
        check("abort_mosi", int'(MOSI), 0);
        check("abort_ldac", int'(LDAC), 1);
        check("abort_ready", int'(o_ready), 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_ldac", ldac_start_q.size(), 0);
        clear_log();
        do_txn(12'h5A5, 12'hA5A, 1'b0, 1'b0);
        wait_done(400);
        check_txn("post_rst", 16'h35A5, 16'hBA5A);

        check("ldac_cs_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
